// File: rtl/membus_pkg.sv
// Shared definitions for the internal 7-bit-address / 8-bit-data memory bus
// and the SPI frame state machine that masters it.
package membus_pkg;

    localparam int MEMBUS_ADDR_W       = 7;
    localparam int MEMBUS_DATA_W       = 8;
    localparam int MEMBUS_CMD_READ_BIT = 7;

    localparam logic [7:0] CO2_BASE_ADDR   = 8'h10;
    localparam logic [7:0] EMPTY_BASE_ADDR = 8'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronises SCK, MOSI and CSN into the system clock domain and derives
// single-cycle edge strobes from the synchronised SCK and CSN.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic csn,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s,
    output logic csn_s
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic                   sck_prev;
    logic                   csn_prev;

    // CSN resets to its idle (high) level so reset release never looks like a frame start.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            csn_sync  <= '1;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            csn_prev  <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall = ~sck_sync[SYNC_STAGES-1] &  sck_prev;
    assign csn_rise =  csn_s & ~csn_prev;
    assign csn_fall = ~csn_s &  csn_prev;

endmodule

// File: rtl/spi_to_memory_bus.sv
// SPI mode-0 slave that masters the internal memory bus (read/write with prefetch).
// Define SPI_ADDR_AUTOINC_EN to auto-increment the address after every data byte.
module spi_to_memory_bus
    import membus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_FILL    = 8'h00,
    parameter bit         ZERO_ON_Z   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     SPI_SCK,
    input  logic                     SPI_CSN,
    input  logic                     SPI_MOSI,
    output logic                     SPI_MISO,
    output logic                     membus_read_req_o,
    output logic                     membus_write_req_o,
    output logic [MEMBUS_ADDR_W-1:0] membus_addr_o,
    output logic [MEMBUS_DATA_W-1:0] membus_data_o,
    input  logic [MEMBUS_DATA_W-1:0] membus_data_i,
    output logic                     busy_o
);

    frame_state_t state, next_state;

    logic                     sck_rise, sck_fall, csn_fall, csn_rise, mosi_s, csn_s;
    logic [2:0]               bit_cnt;
    logic [MEMBUS_DATA_W-2:0] rx;
    logic [MEMBUS_DATA_W-1:0] rx_byte;
    logic [MEMBUS_DATA_W-1:0] tx;
    logic                     capture_q;
    logic                     miso_q;
    logic                     last_bit;

`ifdef SPI_ADDR_AUTOINC_EN
    function automatic logic [MEMBUS_ADDR_W-1:0] next_addr(input logic [MEMBUS_ADDR_W-1:0] a);
        return MEMBUS_ADDR_W'(a + 1'b1);
    endfunction
`else
    function automatic logic [MEMBUS_ADDR_W-1:0] next_addr(input logic [MEMBUS_ADDR_W-1:0] a);
        return a;
    endfunction
`endif

    // Unaddressed slaves float the bus; never let Z/X reach the host.
    function automatic logic [MEMBUS_DATA_W-1:0] scrub(input logic [MEMBUS_DATA_W-1:0] d);
        logic [MEMBUS_DATA_W-1:0] v;
        for (int i = 0; i < MEMBUS_DATA_W; i++)
            v[i] = ZERO_ON_Z ? (d[i] === 1'b1) : d[i];
        return v;
    endfunction

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .sck      (SPI_SCK),
        .csn      (SPI_CSN),
        .mosi     (SPI_MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csn_fall (csn_fall),
        .csn_rise (csn_rise),
        .mosi_s   (mosi_s),
        .csn_s    (csn_s)
    );

    assign rx_byte  = {rx, mosi_s};
    assign last_bit = sck_rise && !csn_s && (bit_cnt == 3'd7);
    assign busy_o   = ~csn_s;
    assign SPI_MISO = miso_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state takes a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (csn_fall) next_state = CMD;
            CMD: begin
                if (csn_rise)      next_state = IDLE;
                else if (last_bit) next_state = rx_byte[MEMBUS_CMD_READ_BIT] ? RD : WR;
            end
            RD, WR:  if (csn_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            membus_read_req_o  <= 1'b0;
            membus_write_req_o <= 1'b0;
            membus_addr_o      <= '0;
            membus_data_o      <= '0;
            bit_cnt            <= '0;
            rx                 <= '0;
            tx                 <= '0;
            capture_q          <= 1'b0;
            miso_q             <= 1'b0;
        end else begin
            membus_read_req_o  <= 1'b0;
            membus_write_req_o <= 1'b0;
            capture_q          <= membus_read_req_o;
`ifdef SPI_ADDR_AUTOINC_EN
            if (membus_write_req_o) membus_addr_o <= next_addr(membus_addr_o);
`endif
            if (state == IDLE) begin
                if (csn_fall) begin
                    bit_cnt <= '0;
                    tx      <= {CMD_FILL[6:0], 1'b0};
                    miso_q  <= CMD_FILL[7];
                end
            end else if (csn_rise) begin
                bit_cnt <= '0;
                miso_q  <= CMD_FILL[7];
            end else begin
                // tx holds the bits still to be shown; MISO takes the next one on each falling edge.
                if (sck_fall) begin
                    miso_q <= tx[MEMBUS_DATA_W-1];
                    tx     <= {tx[MEMBUS_DATA_W-2:0], 1'b0};
                end
                if (sck_rise) begin
                    rx      <= rx_byte[MEMBUS_DATA_W-2:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                membus_addr_o     <= rx_byte[MEMBUS_ADDR_W-1:0];
                                membus_read_req_o <= rx_byte[MEMBUS_CMD_READ_BIT];
                            end
                            RD: begin
                                membus_addr_o     <= next_addr(membus_addr_o);
                                membus_read_req_o <= 1'b1;
                            end
                            WR: begin
                                membus_write_req_o <= 1'b1;
                                membus_data_o      <= rx_byte;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            if (capture_q) tx <= scrub(membus_data_i);
        end
    end

endmodule

// File: tb/tb_spi_to_memory_bus.sv
// Directed bench for spi_to_memory_bus: a host SPI driver, a memory-bus slave model
// and a table of frames with hand-computed results, plus abort and reset sequences.
module tb_spi_to_memory_bus;
    import membus_pkg::*;

`ifdef SPI_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int HALF = 8;

    logic       clk, rst_n, sck, csn, mosi, miso;
    logic       read_req, write_req, busy;
    logic [6:0] addr;
    logic [7:0] wdata, membus_data_i;

    int checks = 0, failures = 0, proto_err = 0;

    spi_to_memory_bus dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .SPI_SCK            (sck),
        .SPI_CSN            (csn),
        .SPI_MOSI           (mosi),
        .SPI_MISO           (miso),
        .membus_read_req_o  (read_req),
        .membus_write_req_o (write_req),
        .membus_addr_o      (addr),
        .membus_data_o      (wdata),
        .membus_data_i      (membus_data_i),
        .busy_o             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: read data appears exactly one clock after the strobe; empty slots float.
    logic [7:0] mem [128];
    logic       present [128];
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data = 8'h00;
    always @(posedge clk) begin
        rd_valid <= read_req;
        rd_data  <= present[addr] ? mem[addr] : 8'hzz;
        if (write_req) mem[addr] <= wdata;
    end
    assign membus_data_i = rd_valid ? rd_data : 8'hzz;

    // Strobe monitor
    logic [6:0]  rd_q [$];
    logic [14:0] wr_q [$];
    logic        rd_prev = 1'b0, wr_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (read_req && write_req) proto_err++;
            if (read_req && rd_prev)   proto_err++;
            if (write_req && wr_prev)  proto_err++;
            if (read_req)  rd_q.push_back(addr);
            if (write_req) wr_q.push_back({addr, wdata});
        end
        rd_prev = read_req;
        wr_prev = write_req;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] b0, b1, b2, input int nb,
                             output logic [7:0] r1, r2);
        logic [7:0] r0;
        rd_q.delete();
        wr_q.delete();
        r1 = 8'h00;
        r2 = 8'h00;
        csn = 1'b0;
        wait_clk(6);
        spi_bits(b0, 8, r0);
        if (nb > 1) spi_bits(b1, 8, r1);
        if (nb > 2) spi_bits(b2, 8, r2);
        wait_clk(6);
        csn = 1'b1;
        wait_clk(20);
    endtask

    typedef struct {
        string      name;
        logic [7:0] b0, b1, b2;
        int         nb;
        bit         is_read;
        logic [7:0] rx1, rx2;
        int         nrd;
        logic [6:0] ra [3];
        int         nwr;
        logic [14:0] wr [2];
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input string name, input logic [7:0] b0, b1, b2, input int nb,
                           input bit is_read, input logic [7:0] rx1, rx2,
                           input int nrd, input logic [6:0] ra0, ra1, ra2,
                           input int nwr, input logic [14:0] w0, w1);
        vec_t v;
        v.name = name; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.nb = nb;
        v.is_read = is_read; v.rx1 = rx1; v.rx2 = rx2;
        v.nrd = nrd; v.ra[0] = ra0; v.ra[1] = ra1; v.ra[2] = ra2;
        v.nwr = nwr; v.wr[0] = w0; v.wr[1] = w1;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] r1, r2;

        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'h00;
            present[i] = (i < 8'h40 || i > 8'h4F);
        end
        mem[7'h10] = 8'h34; mem[7'h11] = 8'h12;
        mem[7'h7F] = 8'h5A; mem[7'h00] = 8'hA5;
        mem[7'h07] = 8'h77;

        rst_n = 1'b0; csn = 1'b1; sck = 1'b0; mosi = 1'b0;

        // Frames: read CO2, write two bytes, read them back, wrap at 0x7F, empty slot.
        add_vec("rd_co2", 8'h90, 8'h00, 8'h00, 3, 1, 8'h34, AUTOINC ? 8'h12 : 8'h34,
                3, 7'h10, AUTOINC ? 7'h11 : 7'h10, AUTOINC ? 7'h12 : 7'h10, 0, '0, '0);
        add_vec("wr_two", 8'h05, 8'hAB, 8'hCD, 3, 0, 8'h00, 8'h00,
                0, '0, '0, '0, 2, {7'h05, 8'hAB}, {AUTOINC ? 7'h06 : 7'h05, 8'hCD});
        add_vec("rd_back", 8'h85, 8'h00, 8'h00, 3, 1, AUTOINC ? 8'hAB : 8'hCD, 8'hCD,
                3, 7'h05, AUTOINC ? 7'h06 : 7'h05, AUTOINC ? 7'h07 : 7'h05, 0, '0, '0);
        add_vec("rd_wrap", 8'hFF, 8'h00, 8'h00, 3, 1, 8'h5A, AUTOINC ? 8'hA5 : 8'h5A,
                3, 7'h7F, AUTOINC ? 7'h00 : 7'h7F, AUTOINC ? 7'h01 : 7'h7F, 0, '0, '0);
        add_vec("rd_empty", 8'hC0, 8'h00, 8'h00, 2, 1, 8'h00, 8'h00,
                2, 7'h40, AUTOINC ? 7'h41 : 7'h40, '0, 0, '0, '0);

        wait_clk(3);
        check("reset_outputs", {miso, read_req, write_req, addr, wdata, busy}, 32'h0);
        rst_n = 1'b1;
        wait_clk(5);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("idle_busy", busy, 1'b0);

        foreach (vecs[v]) begin
            run_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].nb, r1, r2);
            if (vecs[v].is_read) begin
                check($sformatf("%s_rx1", vecs[v].name), r1, vecs[v].rx1);
                if (vecs[v].nb > 2) check($sformatf("%s_rx2", vecs[v].name), r2, vecs[v].rx2);
            end
            check($sformatf("%s_nrd", vecs[v].name), rd_q.size(), vecs[v].nrd);
            for (int i = 0; i < vecs[v].nrd; i++)
                check($sformatf("%s_rd_addr%0d", vecs[v].name, i),
                      (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD, vecs[v].ra[i]);
            check($sformatf("%s_nwr", vecs[v].name), wr_q.size(), vecs[v].nwr);
            for (int i = 0; i < vecs[v].nwr; i++)
                check($sformatf("%s_wr%0d", vecs[v].name, i),
                      (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD, vecs[v].wr[i]);
        end

        // Abort: CSN raised after 4 bits of a write data byte.
        rd_q.delete();
        wr_q.delete();
        csn = 1'b0;
        wait_clk(6);
        spi_bits(8'h07, 8, r1);
        spi_bits(8'hEE, 4, r1);
        wait_clk(6);
        csn = 1'b1;
        wait_clk(20);
        check("abort_no_write", wr_q.size(), 0);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        run_frame(8'h87, 8'h00, 8'h00, 2, r1, r2);
        check("abort_readback", r1, 8'h77);

        // Asynchronous reset in the middle of a read data byte.
        csn = 1'b0;
        wait_clk(6);
        spi_bits(8'h90, 8, r1);
        spi_bits(8'h00, 3, r1);
        check("pre_reset_busy", {busy, addr}, {1'b1, 7'h10});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {miso, read_req, write_req, addr, wdata, busy}, 32'h0);
        csn = 1'b1;
        sck = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(10);
        run_frame(8'h90, 8'h00, 8'h00, 2, r1, r2);
        check("post_reset_rx", r1, 8'h34);
        check("post_reset_rd_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hDEAD, 7'h10);

        check("strobe_protocol", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
